// File: rtl/pushbutton_debouncer.sv
// Push-button front end: 2-flop sync, tick-paced per-channel debounce,
// press/release pulses and a lowest-index key code.
module pushbutton_debouncer #(
    parameter int WIDTH        = 8,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic                     Clk,
    input  logic                     RST_IN,
    input  logic [WIDTH-1:0]         Switch,
    output logic [WIDTH-1:0]         Pressed,
    output logic [WIDTH-1:0]         PressPulse,
    output logic [WIDTH-1:0]         ReleasePulse,
    output logic [$clog2(WIDTH)-1:0] KeyCode,
    output logic                     KeyValid
);

    localparam int KW = $clog2(WIDTH);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] raw_n;
    logic [PW-1:0]    pcnt;
    logic             tick;

    // Sync flops reset to the released (high) level of the raw lines.
    always_ff @(posedge Clk) begin
        if (RST_IN) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= Switch;
            s2 <= s1;
        end
    end

    assign raw_n = ~s2;

    always_ff @(posedge Clk) begin
        if (RST_IN) begin
            pcnt <= '0;
        end else if (pcnt == PMAX) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == PMAX);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          pp;
        logic          rp;
        logic          differ;

        assign differ = raw_n[i] ^ lvl;

        // Any return to the committed level restarts qualification.
        always_ff @(posedge Clk) begin
            if (RST_IN) begin
                cnt <= '0;
                lvl <= 1'b0;
                pp  <= 1'b0;
                rp  <= 1'b0;
            end else begin
                pp <= 1'b0;
                rp <= 1'b0;
                if (!differ) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == LAST) begin
                        lvl <= raw_n[i];
                        pp  <= raw_n[i];
                        rp  <= ~raw_n[i];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign Pressed[i]      = lvl;
        assign PressPulse[i]   = pp;
        assign ReleasePulse[i] = rp;
    end

    // Descending scan so the lowest set index wins.
    always_comb begin
        KeyCode = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (Pressed[i]) KeyCode = KW'(i);
        end
    end

    assign KeyValid = |Pressed;

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Randomised and directed bench for pushbutton_debouncer against a
// run-length / tick-arithmetic reference model.
module tb_pushbutton_debouncer;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         Clk = 1'b0;
    logic         RST_IN;
    logic [W-1:0] Switch;
    logic [W-1:0] Pressed;
    logic [W-1:0] PressPulse;
    logic [W-1:0] ReleasePulse;
    logic [2:0]   KeyCode;
    logic         KeyValid;

    int vectors = 0;
    int miscompares = 0;

    pushbutton_debouncer #(
        .WIDTH(W),
        .TICK_DIV(TD),
        .STABLE_TICKS(ST)
    ) dut (
        .Clk(Clk),
        .RST_IN(RST_IN),
        .Switch(Switch),
        .Pressed(Pressed),
        .PressPulse(PressPulse),
        .ReleasePulse(ReleasePulse),
        .KeyCode(KeyCode),
        .KeyValid(KeyValid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a pending change commits on the edge that
    // completes ST ticks inside one uninterrupted differing run.
    longint       ecount = 0;
    longint       rst_edge = 0;
    bit           model_valid = 1'b0;
    logic [W-1:0] sw_q[$];
    logic [W-1:0] m_pressed, m_pp, m_rp;
    bit           run_active[W];
    longint       run_start[W];

    function automatic longint ticks_in(input longint s, input longint e);
        return (e - rst_edge) / TD - (s - 1 - rst_edge) / TD;
    endfunction

    always @(posedge Clk) begin
        logic [W-1:0] raw;
        ecount++;
        if (RST_IN) begin
            model_valid = 1'b1;
            rst_edge = ecount;
            sw_q = '{W'('1), W'('1)};
            m_pressed = '0;
            m_pp = '0;
            m_rp = '0;
            for (int i = 0; i < W; i++) run_active[i] = 1'b0;
        end else if (model_valid) begin
            raw = ~sw_q[0];
            m_pp = '0;
            m_rp = '0;
            for (int i = 0; i < W; i++) begin
                if (raw[i] == m_pressed[i]) begin
                    run_active[i] = 1'b0;
                end else begin
                    if (!run_active[i]) begin
                        run_active[i] = 1'b1;
                        run_start[i] = ecount;
                    end
                    if ((ecount - rst_edge) % TD == 0 &&
                        ticks_in(run_start[i], ecount) == ST) begin
                        m_pressed[i] = raw[i];
                        m_pp[i] = raw[i];
                        m_rp[i] = ~raw[i];
                        run_active[i] = 1'b0;
                    end
                end
            end
            void'(sw_q.pop_front());
            sw_q.push_back(Switch);
        end
    end

    function automatic logic [2:0] lowest(input logic [W-1:0] v);
        for (int i = 0; i < W; i++) if (v[i]) return 3'(i);
        return 3'd0;
    endfunction

    always @(negedge Clk) begin
        if (model_valid) begin
            chk("pressed", Pressed, m_pressed);
            chk("press_pulse", PressPulse, m_pp);
            chk("release_pulse", ReleasePulse, m_rp);
            chk("keycode", KeyCode, lowest(m_pressed));
            chk("keyvalid", KeyValid, |m_pressed);
            chk("pulse_excl", PressPulse & ReleasePulse, 0);
        end
    end

    task automatic wait_lvl(input int idx, input logic val,
                            output int n, output int pc);
        n = 0;
        pc = 0;
        while (n < 60) begin
            @(negedge Clk);
            n++;
            pc += int'(PressPulse[idx]);
            if (Pressed[idx] == val) return;
        end
        n = -1;
        chk("wait_timeout", 64'(idx), 64'hFFFF);
    endtask

    task automatic count_pp(input int idx, input int cyc, inout int pc);
        repeat (cyc) begin
            @(negedge Clk);
            pc += int'(PressPulse[idx]);
        end
    endtask

    initial begin
        int n, pc;
        Switch = '1;
        RST_IN = 1'b1;
        repeat (3) @(negedge Clk);
        RST_IN = 1'b0;

        repeat (50) begin
            @(negedge Clk);
            chk("t1_quiet", {Pressed, PressPulse, ReleasePulse,
                             KeyCode, KeyValid}, 0);
        end

        Switch[2] = 1'b0;
        wait_lvl(2, 1'b1, n, pc);
        chk("t2_latency_ok", 64'(n >= 11 && n <= 14), 1);
        chk("t2_pressed", Pressed, 8'h04);
        chk("t2_pulse", PressPulse, 8'h04);
        chk("t2_keycode", KeyCode, 2);
        chk("t2_keyvalid", KeyValid, 1);
        @(negedge Clk);
        chk("t2_pulse_gone", PressPulse, 0);

        for (int k = 0; k < 4; k++) begin
            Switch[5] = k[0];
            repeat (k[0] ? 1 : 6) begin
                @(negedge Clk);
                chk("t3_no_commit", Pressed[5], 0);
            end
        end
        Switch[5] = 1'b0;
        wait_lvl(5, 1'b1, n, pc);
        count_pp(5, 20, pc);
        chk("t3_one_pulse", pc, 1);

        Switch[6] = 1'b0;
        Switch[1] = 1'b0;
        wait_lvl(1, 1'b1, n, pc);
        chk("t4_pulse", PressPulse, 8'h42);
        chk("t4_keycode", KeyCode, 1);
        repeat (5) @(negedge Clk);
        Switch[6] = 1'b1;
        wait_lvl(6, 1'b0, n, pc);
        chk("t4_release", ReleasePulse, 8'h40);
        chk("t4_keycode_hold", KeyCode, 1);

        Switch[0] = 1'b0;
        wait_lvl(0, 1'b1, n, pc);
        repeat (3) @(negedge Clk);
        RST_IN = 1'b1;
        @(negedge Clk);
        RST_IN = 1'b0;
        chk("t5_cleared", Pressed, 0);
        chk("t5_no_release", ReleasePulse, 0);
        wait_lvl(0, 1'b1, n, pc);
        chk("t5_latency_ok", 64'(n >= 11 && n <= 14), 1);
        count_pp(0, 20, pc);
        chk("t5_one_pulse", pc, 1);

        repeat ($urandom_range(0, 7)) @(negedge Clk);
        Switch[3] = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            chk("t6_no_commit", Pressed[3], 0);
        end
        Switch[3] = 1'b1;
        repeat (30) begin
            @(negedge Clk);
            chk("t6_no_commit", Pressed[3], 0);
        end

        repeat (4000) begin
            @(negedge Clk);
            RST_IN = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 13) == 0) Switch[i] = ~Switch[i];
        end
        RST_IN = 1'b0;
        repeat (40) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
